// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Words that may be buffered or in flight from the RAM at any time.
    localparam int SKID_DEPTH = 4;

    // Width able to hold 0..SKID_DEPTH for the credit/level counters.
    localparam int CREDIT_W = $clog2(SKID_DEPTH + 1);

    localparam logic [CREDIT_W-1:0] SKID_FULL = CREDIT_W'(SKID_DEPTH);

endpackage

// File: rtl/ram_reader_fifo.sv
// Small skid buffer holding returned RAM words plus their last flag.
module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [W-1:0]        push_data,
    input  logic                pop,
    output logic [W-1:0]        head_data,
    output logic [CREDIT_W-1:0] level
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    logic [W-1:0]     mem [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (level != '0);
    assign do_push   = push && ((level != SKID_FULL) || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + CREDIT_W'(do_push) - CREDIT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a block of RAM words and returns them as a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one RAM read per cycle while credit allows
// DRAIN | all reads issued; waiting for RAM returns and stream to empty
// DONE  | one-cycle done pulse, then back to IDLE
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_dv,
    input  logic [WIDTH-1:0]  i_rd_data,
    output logic              o_tx_valid,
    output logic [WIDTH-1:0]  o_tx_data,
    output logic              o_tx_last,
    input  logic              i_tx_ready
);

    state_t              state;
    state_t              state_nx;
    logic                rd_en_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [ADDR_W:0]     rd_left;
    logic [ADDR_W:0]     rd_left_nx;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     pushed;
    logic [CREDIT_W-1:0] outst;
    logic [CREDIT_W-1:0] fifo_level;
    logic [CREDIT_W-1:0] total_nx;
    logic                push;
    logic                pop;
    logic                last_in;
    logic [WIDTH:0]      head;

    // Returns without a matching outstanding read are dropped (e.g. one in flight across a reset).
    assign push    = i_rd_dv && (outst != '0);
    assign pop     = o_tx_valid && i_tx_ready;
    assign last_in = (pushed + 1'b1) == cnt_q;

    // Buffered plus outstanding once this cycle's read and handshake have settled.
    assign total_nx = fifo_level + outst + CREDIT_W'(o_rd_en) - CREDIT_W'(pop);

    assign o_tx_valid             = (fifo_level != '0);
    assign {o_tx_last, o_tx_data} = head;

    ram_reader_fifo #(
        .W (WIDTH + 1)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data ({last_in, i_rd_data}),
        .pop       (pop),
        .head_data (head),
        .level     (fifo_level)
    );

    // Next-state and next read request; a zero-length request spends one cycle in DRAIN
    // so busy is seen before the done pulse.
    always_comb begin
        state_nx   = state;
        rd_en_nx   = 1'b0;
        addr_nx    = o_rd_addr;
        rd_left_nx = rd_left;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count == '0) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        state_nx   = ST_READ;
                        rd_en_nx   = 1'b1;
                        addr_nx    = i_base_addr;
                        rd_left_nx = i_count - 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rd_left == '0) begin
                    state_nx = ST_DRAIN;
                end else if (total_nx < SKID_FULL) begin
                    rd_en_nx   = 1'b1;
                    addr_nx    = (o_rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : o_rd_addr + 1'b1;
                    rd_left_nx = rd_left - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (total_nx == '0) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            rd_left   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nx;
            o_rd_en   <= rd_en_nx;
            o_rd_addr <= addr_nx;
            rd_left   <= rd_left_nx;
            o_busy    <= (state_nx == ST_READ) || (state_nx == ST_DRAIN);
            o_done    <= (state_nx == ST_DONE);
        end
    end

    // Outstanding-read tracking and word index used to tag the last word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outst  <= '0;
            cnt_q  <= '0;
            pushed <= '0;
        end else begin
            outst <= outst + CREDIT_W'(o_rd_en) - CREDIT_W'(push);
            if ((state == ST_IDLE) && i_start) begin
                cnt_q  <= i_count;
                pushed <= '0;
            end else if (push) begin
                pushed <= pushed + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle-latency RAM model.
module tb_ram_stream_reader;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [ADDR_W:0]   i_count = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              i_rd_dv;
    logic [WIDTH-1:0]  i_rd_data;
    logic              o_tx_valid;
    logic [WIDTH-1:0]  o_tx_data;
    logic              o_tx_last;
    logic              i_tx_ready = 1'b1;

    ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_dv     (i_rd_dv),
        .i_rd_data   (i_rd_data),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .o_tx_last   (o_tx_last),
        .i_tx_ready  (i_tx_ready)
    );

    always #5 i_clk = ~i_clk;

    // RAM read port: exactly one cycle of latency, not affected by the reader's reset.
    logic [WIDTH-1:0] ram [DEPTH];
    int               ram_init [DEPTH] = '{1, 2, 3, 4};
    logic             ram_dv = 1'b0;
    logic [WIDTH-1:0] ram_q = '0;
    always @(posedge i_clk) begin
        ram_dv <= o_rd_en;
        if (o_rd_en) ram_q <= ram[o_rd_addr];
    end
    assign i_rd_dv   = ram_dv;
    assign i_rd_data = ram_q;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    int total = 0;
    int bad   = 0;
    int t0    = 0;

    // Model expectations and per-run logs
    int exp_data[$];
    int exp_last[$];
    int exp_addr[$];
    int hs_rel[$];
    int hs_dat[$];
    int hs_lst[$];
    int done_rel[$];
    int busy_rel[$];
    int rd_addr_log[$];
    int rd_n, valid_n, issued, popped, rd_at_first_hs;

    logic             prev_valid = 1'b0;
    logic             prev_hs = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;
    int               mon_rel;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input int q[$], input int idx, input int exp);
        if (idx < q.size()) chk(name, q[idx], exp);
        else chk(name, -1, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_done"},  int'(o_done), 0);
        chk({tag, "_rd_en"}, int'(o_rd_en), 0);
        chk({tag, "_addr"},  int'(o_rd_addr), 0);
        chk({tag, "_valid"}, int'(o_tx_valid), 0);
        chk({tag, "_data"},  int'(o_tx_data), 0);
        chk({tag, "_last"},  int'(o_tx_last), 0);
    endtask

    task automatic clear_logs();
        hs_rel.delete(); hs_dat.delete(); hs_lst.delete();
        done_rel.delete(); busy_rel.delete(); rd_addr_log.delete();
        rd_n = 0; valid_n = 0; issued = 0; popped = 0; rd_at_first_hs = -1;
    endtask

    task automatic flush_model();
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        issued = 0; popped = 0;
    endtask

    // Compare process: checks every cycle against the model queues and stream rules.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            mon_rel = cyc - t0;
            if (o_rd_en) begin
                rd_n++;
                issued++;
                rd_addr_log.push_back(int'(o_rd_addr));
                if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_addr", int'(o_rd_addr), exp_addr.pop_front());
            end
            if (o_tx_valid) valid_n++;
            if (prev_valid && !prev_hs) begin
                chk("hold_valid", int'(o_tx_valid), 1);
                chk("hold_data", int'(o_tx_data), int'(prev_data));
                chk("hold_last", int'(o_tx_last), int'(prev_last));
            end
            if (o_tx_valid && i_tx_ready) begin
                if (hs_rel.size() == 0) rd_at_first_hs = rd_n;
                hs_rel.push_back(mon_rel);
                hs_dat.push_back(int'(o_tx_data));
                hs_lst.push_back(int'(o_tx_last));
                popped++;
                if (exp_data.size() == 0) chk("tx_extra", 1, 0);
                else begin
                    chk("tx_data", int'(o_tx_data), exp_data.pop_front());
                    chk("tx_last", int'(o_tx_last), exp_last.pop_front());
                end
            end
            if (o_rd_en) chk("credit", int'((issued - popped) <= 4), 1);
            if (o_done) begin
                done_rel.push_back(mon_rel);
                chk("done_busy", int'(o_busy), 0);
            end
            if (o_busy) busy_rel.push_back(mon_rel);
            prev_valid = o_tx_valid;
            prev_hs    = o_tx_valid && i_tx_ready;
            prev_data  = o_tx_data;
            prev_last  = o_tx_last;
        end
    end

    // One transfer: start in relative cycle 0, run for span cycles, optional
    // backpressure window, second start, and reset after N handshakes.
    task automatic run_xfer(input int base, input int cnt, input int bp_lo, input int bp_hi,
                            input int restart_rel, input int rst_after_hs, input int span);
        clear_logs();
        @(posedge i_clk); #1;
        t0          = cyc;
        i_start     = 1'b1;
        i_base_addr = ADDR_W'(base);
        i_count     = (ADDR_W+1)'(cnt);
        i_tx_ready  = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back((base + i) % DEPTH);
            exp_data.push_back(ram_init[(base + i) % DEPTH]);
            exp_last.push_back(int'(i == cnt - 1));
        end
        for (int r = 1; r <= span; r++) begin
            @(posedge i_clk); #1;
            i_start    = (r == restart_rel);
            i_tx_ready = !(r >= bp_lo && r <= bp_hi);
            if (rst_after_hs > 0 && i_rst_n && hs_rel.size() == rst_after_hs) begin
                i_rst_n = 1'b0;
                #1;
                chk_zero("rst_mid");
                flush_model();
            end
        end
        i_start    = 1'b0;
        i_tx_ready = 1'b1;
        chk("words_left", exp_data.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(ram_init[i]);
        clear_logs();

        #2 i_rst_n = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // Sequential read
        run_xfer(0, 4, 100, 0, -1, 0, 12);
        chk("s1_hs_n", hs_rel.size(), 4);
        chk_q("s1_hs0_cyc", hs_rel, 0, 3);
        chk_q("s1_hs3_cyc", hs_rel, 3, 6);
        for (int i = 0; i < 4; i++) chk_q("s1_data", hs_dat, i, i + 1);
        chk_q("s1_last2", hs_lst, 2, 0);
        chk_q("s1_last3", hs_lst, 3, 1);
        chk("s1_done_n", done_rel.size(), 1);
        chk_q("s1_done_cyc", done_rel, 0, 7);
        chk("s1_rd_n", rd_n, 4);
        chk_q("s1_busy_first", busy_rel, 0, 1);
        chk("s1_busy_len", busy_rel.size(), 6);
        chk("s1_valid_n", valid_n, 4);

        // Address wrap
        run_xfer(3, 3, 100, 0, -1, 0, 10);
        chk_q("s2_addr0", rd_addr_log, 0, 3);
        chk_q("s2_addr1", rd_addr_log, 1, 0);
        chk_q("s2_addr2", rd_addr_log, 2, 1);
        chk_q("s2_data0", hs_dat, 0, 4);
        chk_q("s2_data1", hs_dat, 1, 1);
        chk_q("s2_data2", hs_dat, 2, 2);
        chk_q("s2_last2", hs_lst, 2, 1);
        chk_q("s2_done_cyc", done_rel, 0, 6);

        // Backpressure: ready low for cycles 3..8
        run_xfer(0, 4, 3, 8, -1, 0, 20);
        chk("s3_hs_n", hs_rel.size(), 4);
        chk_q("s3_hs0_cyc", hs_rel, 0, 9);
        chk_q("s3_hs3_cyc", hs_rel, 3, 12);
        for (int i = 0; i < 4; i++) chk_q("s3_data", hs_dat, i, i + 1);
        chk("s3_rd_before_pop", int'(rd_at_first_hs >= 1 && rd_at_first_hs <= 4), 1);
        chk("s3_valid_n", valid_n, 10);
        chk_q("s3_done_cyc", done_rel, 0, 13);

        // Zero count
        run_xfer(1, 0, 100, 0, -1, 0, 8);
        chk("s4_rd_n", rd_n, 0);
        chk("s4_valid_n", valid_n, 0);
        chk("s4_done_n", done_rel.size(), 1);
        chk_q("s4_done_cyc", done_rel, 0, 2);
        chk("s4_busy_len", busy_rel.size(), 1);
        chk_q("s4_busy_cyc", busy_rel, 0, 1);

        // Start while busy
        run_xfer(0, 4, 100, 0, 2, 0, 14);
        chk("s5_hs_n", hs_rel.size(), 4);
        chk("s5_rd_n", rd_n, 4);
        chk("s5_done_n", done_rel.size(), 1);
        chk_q("s5_done_cyc", done_rel, 0, 7);

        // Reset after the second handshake
        run_xfer(0, 4, 100, 0, -1, 2, 8);
        chk_q("s6_hs1_cyc", hs_rel, 1, 4);
        chk("s6_done_n", done_rel.size(), 0);
        clear_logs();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("s6_post_done", done_rel.size(), 0);
        chk("s6_post_valid", valid_n, 0);
        chk("s6_post_rd", rd_n, 0);
        run_xfer(0, 2, 100, 0, -1, 0, 10);
        chk("s6_hs_n", hs_rel.size(), 2);
        chk_q("s6_hs0_cyc", hs_rel, 0, 3);
        chk_q("s6_data0", hs_dat, 0, 1);
        chk_q("s6_data1", hs_dat, 1, 2);
        chk_q("s6_last0", hs_lst, 0, 0);
        chk_q("s6_last1", hs_lst, 1, 1);
        chk_q("s6_done_cyc", done_rel, 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
